dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter LOCK_MAX, default 16: maximum consecutive cycles one port may hold a lock, range 2..255.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 reqN  input  1  port N access request (N = 0,1); held until gntN is seen.
REQ-005 weN  input  1  port N write (1) / read (0) qualifier.
REQ-006 lockN  input  1  port N requests exclusive ownership after this grant.
REQ-007 addrN  input  4  port N word address (16 x 8 data memory).
REQ-008 wdataN  input  8  port N write data.
REQ-009 gntN  output  1  port N access accepted this cycle (combinational).
REQ-010 rvalidN  output  1  port N read data valid, one-cycle pulse (registered).
REQ-011 rdataN  output  8  port N read data, registered, held until next port N read.
REQ-012 mem_addr  output  4  address to data memory.
REQ-013 mem_wdata  output  8  write data to data memory.
REQ-014 mem_we  output  1  write enable to data memory (memory writes at posedge).
REQ-015 mem_rdata  input  8  combinational read data from data memory.

Function
REQ-016 FSM states SHALL be ARB, LOCK0, LOCK1; one access maximum per cycle.
REQ-017 ARB: exactly one requester -> that port granted; both -> port indicated by prio register granted.
REQ-018 ARB: after any grant, prio SHALL point to the non-granted port (round robin); no grant -> prio unchanged.
REQ-019 ARB: granted port with lockN=1 -> next state LOCKN, lock counter cleared to 0.
REQ-020 LOCKN: gntN = reqN; other port's gnt SHALL be 0 regardless of its req.
REQ-021 LOCKN: grant with lockN=0 -> next state ARB, prio to other port (lock released after that access).
REQ-022 LOCKN: counter increments every cycle in LOCKN; on reaching LOCK_MAX-1 -> next state ARB, prio to other port, regardless of lockN (forced release; that cycle's access still performed if granted).
REQ-023 LOCKN with reqN=0: no access, state held, counter still increments.
REQ-024 Granted cycle: mem_addr/mem_wdata/mem_we driven from winner's addr/wdata/we; no grant -> mem_addr=0, mem_wdata=0, mem_we=0.
REQ-025 Granted read: rdataN <= mem_rdata at the same edge; rvalidN=1 the following cycle only; latency 1 cycle.
REQ-026 Granted write: no rvalid pulse; write visible to a read granted in any later cycle.
REQ-027 Back-to-back: a port may be granted every cycle; rvalid pulses SHALL align one cycle after each read grant.
REQ-028 Ungranted request: port SHALL see gntN=0 and no memory side effect; request info not latched.

Reset
REQ-029 rst_n low SHALL immediately force: state ARB, prio=0, counter=0, rvalid0/1=0, rdata0/1=0, gnt0/1=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-030 Reset asserted mid-lock or mid-read SHALL discard the pending rvalid and the lock; release on synchronous clk edge after rst_n high, first grant no earlier than that edge.

Verification
REQ-031 Memory word 0=7, word 3=1; req0 read addr 0 alone -> gnt0=1 same cycle, next cycle rvalid0=1, rdata0=8'h07, prio=1.
REQ-032 req0 and req1 reads (addr 0, addr 3) held from reset -> cycle 1 gnt0, cycle 2 gnt1; rdata0=7, rdata1=1, alternating thereafter.
REQ-033 Port1 lock read addr 3 then write addr 3=8'h2A with lock=0, port0 requesting throughout -> gnt0=0 both cycles, then ARB grants port0; a port0 read of addr 3 returns 8'h2A.
REQ-034 Port0 holds lock=1 and req0=1 for 20 cycles, LOCK_MAX=16, req1=1 -> port0 granted 16 cycles, port1 granted on cycle 17.
REQ-035 rst_n pulsed low during LOCK1 with read granted the prior cycle -> rvalid1=0, gnt=0, mem_we=0 during reset; after release both reqs -> port0 granted first.
REQ-036 Both ports write same address in same cycle, prio=1 -> only port1 written, gnt0=0, port0 written next cycle.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between two requesting ports, the arbiter and a 16 x 8 data memory.
// The arbiter takes the slave view; requesters plus memory take the master view.
interface dmem_arbiter_if;
  logic       req0;
  logic       we0;
  logic       lock0;
  logic [3:0] addr0;
  logic [7:0] wdata0;
  logic       gnt0;
  logic       rvalid0;
  logic [7:0] rdata0;

  logic       req1;
  logic       we1;
  logic       lock1;
  logic [3:0] addr1;
  logic [7:0] wdata1;
  logic       gnt1;
  logic       rvalid1;
  logic [7:0] rdata1;

  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] mem_rdata;

  modport slave (
    input  req0, we0, lock0, addr0, wdata0,
    input  req1, we1, lock1, addr1, wdata1,
    input  mem_rdata,
    output gnt0, rvalid0, rdata0,
    output gnt1, rvalid1, rdata1,
    output mem_addr, mem_wdata, mem_we
  );

  modport master (
    output req0, we0, lock0, addr0, wdata0,
    output req1, we1, lock1, addr1, wdata1,
    output mem_rdata,
    input  gnt0, rvalid0, rdata0,
    input  gnt1, rvalid1, rdata1,
    input  mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin data-memory arbiter with bounded exclusive locks.
// One access per cycle; read data is registered and flagged by a one-cycle rvalid.
module dmem_arbiter #(
  parameter int unsigned LOCK_MAX = 16
) (
  input logic           clk,
  input logic           rst_n,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_t;

  state_t     state, state_nxt;
  logic       prio, prio_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       active;
  logic       gnt0, gnt1;
  logic       cnt_done;
  logic       rvalid0, rvalid1;
  logic [7:0] rdata0, rdata1;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;

  // The counter is checked before its increment, so release fires when the
  // incremented value would reach LOCK_MAX-1: LOCK_MAX grants including the ARB one.
  assign cnt_done = (cnt == 8'(LOCK_MAX - 2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ARB;
      prio   <= 1'b0;
      cnt    <= '0;
      active <= 1'b0;
    end else begin
      state  <= state_nxt;
      prio   <= prio_nxt;
      cnt    <= cnt_nxt;
      active <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    prio_nxt  = prio;
    cnt_nxt   = cnt;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    unique case (state)
      ARB: begin
        cnt_nxt = '0;
        if (active) begin
          if (bus.req0 && (!bus.req1 || !prio)) gnt0 = 1'b1;
          else if (bus.req1)                    gnt1 = 1'b1;
        end
        if (gnt0) begin
          prio_nxt = 1'b1;
          if (bus.lock0) state_nxt = LOCK0;
        end else if (gnt1) begin
          prio_nxt = 1'b0;
          if (bus.lock1) state_nxt = LOCK1;
        end
      end
      LOCK0: begin
        gnt0    = bus.req0 && active;
        cnt_nxt = cnt + 8'd1;
        if (cnt_done || (gnt0 && !bus.lock0)) begin
          state_nxt = ARB;
          prio_nxt  = 1'b1;
        end
      end
      LOCK1: begin
        gnt1    = bus.req1 && active;
        cnt_nxt = cnt + 8'd1;
        if (cnt_done || (gnt1 && !bus.lock1)) begin
          state_nxt = ARB;
          prio_nxt  = 1'b0;
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (gnt0) begin
      mem_addr  = bus.addr0;
      mem_wdata = bus.wdata0;
      mem_we    = bus.we0;
    end else if (gnt1) begin
      mem_addr  = bus.addr1;
      mem_wdata = bus.wdata1;
      mem_we    = bus.we1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= gnt0 && !bus.we0;
      rvalid1 <= gnt1 && !bus.we1;
      if (gnt0 && !bus.we0) rdata0 <= bus.mem_rdata;
      if (gnt1 && !bus.we1) rdata1 <= bus.mem_rdata;
    end
  end

  assign bus.gnt0      = gnt0;
  assign bus.gnt1      = gnt1;
  assign bus.rvalid0   = rvalid0;
  assign bus.rvalid1   = rvalid1;
  assign bus.rdata0    = rdata0;
  assign bus.rdata1    = rdata1;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.mem_we    = mem_we;

  a_one_grant: assert property (@(posedge clk) disable iff (!rst_n) !(gnt0 && gnt1));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic, checked
// against an ownership/budget reference model and a shadow copy of memory.
module tb_dmem_arbiter;
  localparam int unsigned LOCK_MAX = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic load;

  dmem_arbiter_if bus();

  dmem_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Environment memory: combinational read, write on posedge.
  logic [7:0] mem [16];
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
      mem[0] <= 8'h07;
      mem[3] <= 8'h01;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  // Reference model: who owns the bus, how many locked cycles remain, whose turn.
  int         m_owner;
  int         m_left;
  logic       m_prio;
  logic       m_active;
  logic [7:0] ref_mem [16];
  logic       e_g0, e_g1, e_we, e_rv0, e_rv1;
  logic [3:0] e_addr;
  logic [7:0] e_wdata, e_rd0, e_rd1;

  int errors = 0;
  int checks = 0;

  function automatic logic [32:0] observed();
    return {bus.gnt0, bus.gnt1, bus.mem_we, bus.mem_addr, bus.mem_wdata,
            bus.rvalid0, bus.rvalid1, bus.rdata0, bus.rdata1};
  endfunction

  function automatic logic [32:0] expected();
    return {e_g0, e_g1, e_we, e_addr, e_wdata, e_rv0, e_rv1, e_rd0, e_rd1};
  endfunction

  task automatic sample();
    @(negedge clk);
    if (!rst_n) begin
      m_active = 1'b0; m_owner = -1; m_left = 0; m_prio = 1'b0;
      e_rv0 = 1'b0; e_rv1 = 1'b0; e_rd0 = 8'h00; e_rd1 = 8'h00;
    end
    e_g0 = 1'b0;
    e_g1 = 1'b0;
    if (m_active) begin
      if (m_owner == 0)      e_g0 = bus.req0;
      else if (m_owner == 1) e_g1 = bus.req1;
      else if (bus.req0 && bus.req1) begin
        if (m_prio) e_g1 = 1'b1; else e_g0 = 1'b1;
      end else begin
        e_g0 = bus.req0;
        e_g1 = bus.req1;
      end
    end
    e_we    = e_g0 ? bus.we0    : e_g1 ? bus.we1    : 1'b0;
    e_addr  = e_g0 ? bus.addr0  : e_g1 ? bus.addr1  : 4'h0;
    e_wdata = e_g0 ? bus.wdata0 : e_g1 ? bus.wdata1 : 8'h00;
  endtask

  task automatic clock();
    @(posedge clk);
    if (rst_n) begin
      e_rv0 = e_g0 && !bus.we0;
      e_rv1 = e_g1 && !bus.we1;
      if (e_rv0) e_rd0 = ref_mem[bus.addr0];
      if (e_rv1) e_rd1 = ref_mem[bus.addr1];
      if (e_we) ref_mem[e_addr] = e_wdata;
      if (m_owner >= 0) begin
        m_left--;
        if (m_left == 0 ||
            (m_owner == 0 ? (e_g0 && !bus.lock0) : (e_g1 && !bus.lock1))) begin
          m_prio  = (m_owner == 0);
          m_owner = -1;
        end
      end else if (e_g0 || e_g1) begin
        m_prio = e_g0;
        if (e_g0 && bus.lock0)      begin m_owner = 0; m_left = LOCK_MAX - 1; end
        else if (e_g1 && bus.lock1) begin m_owner = 1; m_left = LOCK_MAX - 1; end
      end
      m_active = 1'b1;
    end
    #1;
  endtask

  task automatic drive0(input logic req, input logic we, input logic lock,
                        input logic [3:0] addr, input logic [7:0] wdata);
    bus.req0 = req; bus.we0 = we; bus.lock0 = lock; bus.addr0 = addr; bus.wdata0 = wdata;
  endtask

  task automatic drive1(input logic req, input logic we, input logic lock,
                        input logic [3:0] addr, input logic [7:0] wdata);
    bus.req1 = req; bus.we1 = we; bus.lock1 = lock; bus.addr1 = addr; bus.wdata1 = wdata;
  endtask

  task automatic idle();
    drive0(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    drive1(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
  endtask

  task automatic reset_dut();
    idle();
    rst_n = 1'b0;
    sample(); clock();
    rst_n = 1'b1;
    sample(); clock();
  endtask

  task automatic test_reset();
    drive0(1'b1, 1'b1, 1'b1, 4'h5, 8'hA5);
    drive1(1'b1, 1'b1, 1'b1, 4'h6, 8'h5A);
    sample();
    if (observed() !== 33'h0) begin
      errors++; $display("FAIL reset_outputs: got %h want %h", observed(), 33'h0);
    end
    checks++;
    load = 1'b0;
    clock();
    rst_n = 1'b1;
    sample();
    if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0 || observed() !== expected()) begin
      errors++; $display("FAIL release_no_grant: got %h want %h", observed(), expected());
    end
    checks++;
    clock();
  endtask

  task automatic test_single_read();
    idle();
    drive0(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
    sample();
    if (bus.gnt0 !== 1'b1 || observed() !== expected()) begin
      errors++; $display("FAIL single_read_gnt: got %h want %h", observed(), expected());
    end
    checks++;
    clock();
    idle();
    sample();
    if (bus.rvalid0 !== 1'b1 || bus.rdata0 !== 8'h07 || observed() !== expected()) begin
      errors++; $display("FAIL single_read_data: got rv=%b rd=%h want rv=1 rd=07", bus.rvalid0, bus.rdata0);
    end
    checks++;
    clock();
    drive0(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
    drive1(1'b1, 1'b0, 1'b0, 4'h3, 8'h00);
    sample();
    if (bus.gnt1 !== 1'b1 || bus.gnt0 !== 1'b0 || observed() !== expected()) begin
      errors++; $display("FAIL prio_after_read: got g0=%b g1=%b want g0=0 g1=1", bus.gnt0, bus.gnt1);
    end
    checks++;
    clock();
    idle();
  endtask

  task automatic test_alternating();
    idle();
    rst_n = 1'b0;
    drive0(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
    drive1(1'b1, 1'b0, 1'b0, 4'h3, 8'h00);
    sample(); clock();
    rst_n = 1'b1;
    sample(); clock();
    for (int i = 0; i < 6; i++) begin
      sample();
      if (observed() !== expected() || ((i % 2 == 0) ? bus.gnt0 : bus.gnt1) !== 1'b1) begin
        errors++; $display("FAIL alternate cyc %0d: got %h want %h", i, observed(), expected());
      end
      checks++;
      if (i >= 2 && (bus.rdata0 !== 8'h07 || bus.rdata1 !== 8'h01)) begin
        errors++; $display("FAIL alternate_data cyc %0d: got %h/%h want 07/01", i, bus.rdata0, bus.rdata1);
      end
      checks++;
      clock();
    end
    idle();
  endtask

  task automatic test_lock_release();
    reset_dut();
    drive0(1'b1, 1'b0, 1'b0, 4'h1, 8'h00);
    sample(); clock();
    drive0(1'b1, 1'b0, 1'b0, 4'h3, 8'h00);
    drive1(1'b1, 1'b0, 1'b1, 4'h3, 8'h00);
    sample();
    if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b1 || observed() !== expected()) begin
      errors++; $display("FAIL lock_read: got %h want %h", observed(), expected());
    end
    checks++;
    clock();
    drive1(1'b1, 1'b1, 1'b0, 4'h3, 8'h2A);
    sample();
    if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b1 || observed() !== expected()) begin
      errors++; $display("FAIL lock_write: got %h want %h", observed(), expected());
    end
    checks++;
    clock();
    drive1(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    sample();
    if (bus.gnt0 !== 1'b1 || observed() !== expected()) begin
      errors++; $display("FAIL unlock_grant: got %h want %h", observed(), expected());
    end
    checks++;
    clock();
    idle();
    sample();
    if (bus.rvalid0 !== 1'b1 || bus.rdata0 !== 8'h2A || observed() !== expected()) begin
      errors++; $display("FAIL locked_write_visible: got rd=%h want 2a", bus.rdata0);
    end
    checks++;
    clock();
  endtask

  task automatic test_lock_timeout();
    int first_g1 = 0;
    int g0_count = 0;
    reset_dut();
    drive0(1'b1, 1'b0, 1'b1, 4'h0, 8'h00);
    drive1(1'b1, 1'b0, 1'b0, 4'h3, 8'h00);
    for (int i = 1; i <= 20; i++) begin
      sample();
      if (observed() !== expected()) begin
        errors++; $display("FAIL lock_timeout cyc %0d: got %h want %h", i, observed(), expected());
      end
      checks++;
      if (bus.gnt1 === 1'b1 && first_g1 == 0) first_g1 = i;
      if (bus.gnt0 === 1'b1 && first_g1 == 0) g0_count++;
      clock();
    end
    if (first_g1 != 17 || g0_count != 16) begin
      errors++; $display("FAIL lock_budget: got g0=%0d first_g1=%0d want 16/17", g0_count, first_g1);
    end
    checks++;
    idle();
  endtask

  task automatic test_reset_mid_lock();
    reset_dut();
    drive1(1'b1, 1'b0, 1'b1, 4'h3, 8'h00);
    sample(); clock();
    sample();
    if (bus.gnt1 !== 1'b1 || observed() !== expected()) begin
      errors++; $display("FAIL mid_lock_read: got %h want %h", observed(), expected());
    end
    checks++;
    clock();
    rst_n = 1'b0;
    drive0(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
    drive1(1'b1, 1'b0, 1'b0, 4'h3, 8'h00);
    sample();
    if (bus.rvalid1 !== 1'b0 || bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0 ||
        bus.mem_we !== 1'b0 || observed() !== expected()) begin
      errors++; $display("FAIL reset_mid_lock: got %h want %h", observed(), expected());
    end
    checks++;
    clock();
    rst_n = 1'b1;
    sample(); clock();
    sample();
    if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0 || observed() !== expected()) begin
      errors++; $display("FAIL post_reset_first: got g0=%b g1=%b want g0=1 g1=0", bus.gnt0, bus.gnt1);
    end
    checks++;
    clock();
    idle();
  endtask

  task automatic test_same_addr_write();
    reset_dut();
    drive0(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
    sample(); clock();
    drive0(1'b1, 1'b1, 1'b0, 4'h5, 8'h11);
    drive1(1'b1, 1'b1, 1'b0, 4'h5, 8'h22);
    sample();
    if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b1 || bus.mem_wdata !== 8'h22 || observed() !== expected()) begin
      errors++; $display("FAIL collide_first: got %h want %h", observed(), expected());
    end
    checks++;
    clock();
    drive1(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    sample();
    if (bus.gnt0 !== 1'b1 || bus.mem_wdata !== 8'h11 || observed() !== expected()) begin
      errors++; $display("FAIL collide_second: got %h want %h", observed(), expected());
    end
    checks++;
    clock();
    idle();
    drive1(1'b1, 1'b0, 1'b0, 4'h5, 8'h00);
    sample(); clock();
    idle();
    sample();
    if (bus.rdata1 !== 8'h11 || observed() !== expected()) begin
      errors++; $display("FAIL collide_final: got rd1=%h want 11", bus.rdata1);
    end
    checks++;
    clock();
  endtask

  task automatic test_random();
    reset_dut();
    for (int i = 0; i < 400; i++) begin
      if (!bus.req0 || e_g0)
        drive0(($urandom % 3) != 0, $urandom % 2, ($urandom % 4) == 0,
               4'($urandom % 8), 8'($urandom));
      if (!bus.req1 || e_g1)
        drive1(($urandom % 3) != 0, $urandom % 2, ($urandom % 4) == 0,
               4'($urandom % 8), 8'($urandom));
      if (($urandom % 120) == 0) rst_n = 1'b0;
      sample();
      if (observed() !== expected()) begin
        errors++; $display("FAIL random cyc %0d: got %h want %h", i, observed(), expected());
      end
      checks++;
      clock();
      rst_n = 1'b1;
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    ref_mem[0] = 8'h07;
    ref_mem[3] = 8'h01;
    m_owner = -1; m_left = 0; m_prio = 1'b0; m_active = 1'b0;
    e_g0 = 1'b0; e_g1 = 1'b0; e_rv0 = 1'b0; e_rv1 = 1'b0;
    load  = 1'b1;
    rst_n = 1'b0;
    idle();
    test_reset();
    test_single_read();
    test_alternating();
    test_lock_release();
    test_lock_timeout();
    test_reset_mid_lock();
    test_same_addr_write();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
